// File: rtl/overflow_guard_accum.sv
// Frame accumulator behind a WIDTH-bit adder with full-carry overflow detection.
// Optional build macro ACCUM_SAT_EN: saturate acc on overflow instead of wrapping.
module overflow_guard_accum #(
  parameter int WIDTH = 4,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf,
  output logic [7:0]       ovf_frames
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2,
    SPARE = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(COUNT);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             flag_q, flag_d;
  logic [7:0]       frames_q, frames_d;
  logic             rdy_q;
  logic             ov_q, ov_d;
  logic [WIDTH-1:0] os_q, os_d;
  logic             oo_q, oo_d;

  logic [WIDTH:0]   psum;
  logic [WIDTH-1:0] base;
  logic [WIDTH+1:0] total;
  logic             ovf_ev;
  logic [WIDTH-1:0] acc_nx;
  logic [7:0]       cnt_inc;
  logic             accept;

  assign in_ready = rdy_q &&
                    (state_q == IDLE || state_q == ACCUM);
  assign accept   = in_valid && in_ready;
  assign cnt_inc  = cnt_q + 8'd1;

  // Two guard bits keep the sum exact; overflow is any carry out of WIDTH.
  always_comb begin
    psum   = {1'b0, in_a} + {1'b0, in_b};
    base   = (state_q == IDLE) ? '0 : acc_q;
    total  = {2'b00, base} + {1'b0, psum};
    ovf_ev = |total[WIDTH+1:WIDTH];
`ifdef ACCUM_SAT_EN
    acc_nx = ovf_ev ? '1 : total[WIDTH-1:0];
`else
    acc_nx = total[WIDTH-1:0];
`endif
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    flag_d   = flag_q;
    frames_d = frames_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = acc_nx;
          cnt_d   = 8'd1;
          flag_d  = ovf_ev;
          state_d = (COUNT == 1) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d  = acc_nx;
          cnt_d  = cnt_inc;
          flag_d = flag_q | ovf_ev;
          if (cnt_inc == CNT_LAST)
            state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          flag_d  = 1'b0;
          if (flag_q && frames_q != 8'hFF)
            frames_d = frames_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        flag_d  = 1'b0;
      end
    endcase
  end

  // Result registers mirror HOLD so they are stable for the whole stall.
  always_comb begin
    ov_d = (state_d == HOLD);
    os_d = (state_d == HOLD) ? acc_d : '0;
    oo_d = (state_d == HOLD) ? flag_d : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      flag_q   <= 1'b0;
      frames_q <= '0;
      rdy_q    <= 1'b0;
      ov_q     <= 1'b0;
      os_q     <= '0;
      oo_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      flag_q   <= flag_d;
      frames_q <= frames_d;
      rdy_q    <= 1'b1;
      ov_q     <= ov_d;
      os_q     <= os_d;
      oo_q     <= oo_d;
    end
  end

  assign out_valid  = ov_q;
  assign out_sum    = os_q;
  assign out_ovf    = oo_q;
  assign ovf_frames = frames_q;

endmodule

// File: tb/tb_overflow_guard_accum.sv
// Bench for overflow_guard_accum: frame table, scoreboard, corner sequences.
// Expected sums follow the ACCUM_SAT_EN build selection.
module tb_overflow_guard_accum;

`ifdef ACCUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] out_sum;
  logic       out_ovf;
  logic [7:0] ovf_frames;

  overflow_guard_accum #(.WIDTH(4), .COUNT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_ovf    (out_ovf),
    .ovf_frames (ovf_frames)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  s;
    logic        o;
  } vec_t;

  typedef struct packed {
    logic [3:0] s;
    logic       o;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t sb[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got sum %0h expected none", out_sum);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_sum", 32'(out_sum), 32'(e.s));
        chk("out_ovf", 32'(out_ovf), 32'(e.o));
      end
    end
  end

  function automatic vec_t mk(input logic [15:0] a,
                              input logic [15:0] b,
                              input logic [3:0]  s,
                              input logic        o);
    vec_t v;
    v.a = a;
    v.b = b;
    v.s = s;
    v.o = o;
    return v;
  endfunction

  task automatic send(input logic [3:0] a, input logic [3:0] b);
    int tries;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    tries = 0;
    while (!in_ready && tries < 100) begin
      @(posedge clk); #1;
      tries++;
    end
    if (tries >= 100) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input vec_t v);
    exp_t e;
    e.s = v.s;
    e.o = v.o;
    sb.push_back(e);
    for (int i = 0; i < 4; i++)
      send(v.a[15-4*i -: 4], v.b[15-4*i -: 4]);
    in_valid = 1'b0;
    in_a = 'x;
    in_b = 'x;
    chk("latency_out_valid", 32'(out_valid), 32'd1);
  endtask

  vec_t tbl[6];
  vec_t v;
  int   nov;
  int   c0;

  initial begin
    tbl[0] = mk(16'h1021, 16'h2320, 4'hB, 1'b0);
    tbl[1] = mk(16'h8100, 16'h8101, SAT ? 4'hF : 4'h3, 1'b1);
    tbl[2] = mk(16'hF000, 16'hF000, SAT ? 4'hF : 4'hE, 1'b1);
    tbl[3] = mk(16'h7000, 16'h7100, 4'hF, 1'b0);
    tbl[4] = mk(16'h0000, 16'h0000, 4'h0, 1'b0);
    tbl[5] = mk(16'h8000, 16'h7001, SAT ? 4'hF : 4'h0, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_out_valid2", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("rst_ovf_frames", 32'(ovf_frames), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    nov = 0;
    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i]);
      nov += int'(tbl[i].o);
      @(posedge clk); #1;
      chk("tbl_ovf_frames", 32'(ovf_frames), 32'(nov));
      chk("tbl_turn_in_ready", 32'(in_ready), 32'd1);
      chk("tbl_turn_out_valid", 32'(out_valid), 32'd0);
    end

    out_ready = 1'b0;
    send_frame(tbl[0]);
    in_valid = 1'b1;
    in_a = 4'd5;
    in_b = 4'd5;
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_out_sum", 32'(out_sum), 32'hB);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_in_ready", 32'(in_ready), 32'd1);
    c0 = cyc;
    send_frame(mk(16'h5100, 16'h5000, 4'hB, 1'b0));
    chk("turnaround_cycles", 32'(cyc - c0), 32'd4);
    @(posedge clk); #1;

    send(4'd3, 4'd3);
    send(4'd3, 4'd3);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #2;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_ovf_frames", 32'(ovf_frames), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready_up", 32'(in_ready), 32'd1);
    send_frame(mk(16'h1111, 16'h1111, 4'h8, 1'b0));
    @(posedge clk); #1;
    chk("midrst_frames_clean", 32'(ovf_frames), 32'd0);

    v = mk(16'h8888, 16'h8888, SAT ? 4'hF : 4'h0, 1'b1);
    for (int k = 1; k <= 300; k++) begin
      send_frame(v);
      @(posedge clk); #1;
      if (k == 254) chk("sat_254", 32'(ovf_frames), 32'd254);
      if (k == 255) chk("sat_255", 32'(ovf_frames), 32'd255);
      if (k == 300) chk("sat_hold", 32'(ovf_frames), 32'd255);
    end

    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/overflow_guard_accum.md
Name: overflow_guard_accum

Overview:
- Registered, lint-clean consumer of a 4-bit adder stage.
- Accepts operand pairs over a valid/ready handshake and adds each pair with full carry.
- Accumulates a frame of COUNT pair-sums and presents one result per frame with a sticky overflow flag.
- Fixes the truncated-sum hazard of a bare WIDTH-bit adder and closes the FSM with a full, default-covered case.

Parameters:
- WIDTH, 4, operand and result width in bits.
- COUNT, 4, pair-sums per frame; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept a pair this cycle.
- in_a  input  WIDTH  operand A, unsigned.
- in_b  input  WIDTH  operand B, unsigned.
- out_valid  output  1  frame result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  WIDTH  frame accumulation result.
- out_ovf  output  1  at least one overflow event occurred in the frame.
- ovf_frames  output  8  saturating count of frames with out_ovf=1.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, acc=0, cnt=0, ovf flag=0, ovf_frames=0, out_valid=0, out_sum=0, out_ovf=0. in_ready=1 from the first edge after rst_n deasserts.
- Accept event: in_valid && in_ready at the clk rising edge.
- Arithmetic:
  - psum = in_a + in_b, computed in WIDTH+1 bits.
  - total = acc + psum, computed in WIDTH+2 bits; cannot wrap internally.
  - Overflow event when total >= 2^WIDTH.
  - acc update on overflow depends on ACCUM_SAT_EN (see Optional Feature); otherwise acc=total.
- FSM: 2-bit state, default branch returns to IDLE, and every state-encoding value is covered.
  - IDLE: in_ready=1, out_valid=0.
    - On accept, acc is loaded from the overflow rule applied to 0+psum.
    - cnt is set to 1 and the flag is set to the event value.
    - Next state is HOLD if COUNT==1, else ACCUM.
  - ACCUM: in_ready=1.
    - On accept, acc updates, cnt increments, and flag |= event.
    - Next state is HOLD when cnt+1==COUNT.
    - With no accept, all registers hold.
  - HOLD: in_ready=0, out_valid=1, out_sum=acc, out_ovf=flag.
    - Outputs stay stable until out_ready.
    - On out_ready, next state is IDLE, and acc, cnt and flag clear.
    - On the same edge, ovf_frames increments if flag=1, saturating at 255.
- Latency: out_valid asserts the cycle after the COUNT-th accept. Handshake turnaround: one idle cycle after result acceptance; IDLE accepts on the next edge.
- No simultaneous input accept and output drain: in_ready=0 throughout HOLD.
- in_a/in_b are ignored when no accept occurs; X on them while in_valid=0 must not propagate.
- Reset mid-frame: immediate clear to reset values; any partial frame is discarded.
- out_* are registered; in_ready is combinational from state only, never from in_valid.

Optional Feature:
- Macro: ACCUM_SAT_EN.
- Defined: on an overflow event, acc=2^WIDTH-1 (saturate).
- Undefined: acc=total[WIDTH-1:0] (modulo wrap).
- out_ovf, ovf_frames and handshake behaviour are identical in both builds.

Test Plan (WIDTH=4, COUNT=4):
- Reset: hold rst_n=0 for 3 cycles, then release -> out_valid=0, out_sum=0, out_ovf=0, ovf_frames=0, in_ready=1.
- Clean frame: pairs (1,2),(0,3),(2,2),(1,0) on consecutive cycles -> out_valid the cycle after the 4th accept; out_sum=4'hB, out_ovf=0.
- Overflow frame: pairs (8,8),(1,1),(0,0),(0,1).
  - With ACCUM_SAT_EN: out_sum=4'hF, out_ovf=1.
  - Without it: out_sum=4'h3, out_ovf=1.
  - Both builds: after drain, ovf_frames=1.
- Backpressure:
  - Stimulus: during HOLD, out_ready=0 for 5 cycles with in_valid=1.
  - During the stall: in_ready=0, no pair consumed, out_sum stable.
  - After out_ready=1 for one cycle: IDLE, then the next pair is accepted one cycle later.
- Mid-frame reset: assert rst_n=0 asynchronously after 2 accepts, then send a full clean frame (1,1)x4 -> out_sum=4'h8, out_ovf=0.
- Counter saturation: 300 consecutive overflow frames -> ovf_frames reaches 255 and stays 255.
